// File: rtl/us_stream_pkg.sv
// Shared types and widths for the ultrasound upstream frame source.
package us_stream_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned WORD_W   = 32;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTrig,
        StCapture,
        StDrain,
        StEof
    } state_e;

endpackage

// File: rtl/us_frame_source_if.sv
// Xillybus 32-bit upstream read pipe between the user producer and the core.
interface us_frame_source_if;

    logic                                user_r_read_32_open;
    logic                                user_r_read_32_rden;
    logic [us_stream_pkg::WORD_W-1:0]    user_r_read_32_data;
    logic                                user_r_read_32_empty;
    logic                                user_r_read_32_eof;

    // Producer side (user logic).
    modport master (
        input  user_r_read_32_open,
        input  user_r_read_32_rden,
        output user_r_read_32_data,
        output user_r_read_32_empty,
        output user_r_read_32_eof
    );

    // Consumer side (Xillybus core).
    modport slave (
        output user_r_read_32_open,
        output user_r_read_32_rden,
        input  user_r_read_32_data,
        input  user_r_read_32_empty,
        input  user_r_read_32_eof
    );

endinterface

// File: rtl/us_sync_fifo.sv
// Synchronous FIFO with registered read data; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module us_sync_fifo #(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned WORD_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WORD_W-1:0]     push_data,
    input  logic                  pop,
    output logic [WORD_W-1:0]     rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DepthCnt = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WORD_W-1:0]     mem [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [WORD_W-1:0]     rd_data_q;
    logic                  do_push, do_pop;

    assign full    = (count_q == DepthCnt);
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Registered read port, one cycle after the pop strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (do_pop) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;

endmodule

// File: rtl/us_frame_source.sv
// Packs 16-bit ADC samples into 32-bit words and serves one EOF-terminated
// frame per open+trigger over the Xillybus upstream pipe.
module us_frame_source
    import us_stream_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 9,
    parameter int unsigned FRAME_WORDS = 4096
) (
    input  logic                 bus_clk_w,
    input  logic                 bus_rst_n_w,
    input  logic [SAMPLE_W-1:0]  sample_in,
    input  logic                 sample_valid,
    input  logic                 trigger,
    us_frame_source_if.master    pipe,
    output logic                 overflow,
    output logic                 frame_active
);

    localparam int unsigned CntW = $clog2(FRAME_WORDS + 1);
    localparam logic [CntW-1:0] LastWord = CntW'(FRAME_WORDS - 1);

    state_e                state_q, state_d;
    logic                  half_q, half_d;
    logic [SAMPLE_W-1:0]   low_q, low_d;
    logic [CntW-1:0]       word_cnt_q, word_cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  push, flush, blocked;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  fifo_full, fifo_empty;

    // A push is lost only when full and no read frees a slot this cycle.
    assign blocked = fifo_full && !(pipe.user_r_read_32_rden && !fifo_empty);

    // State, packing and frame-counter registers.
    always_ff @(posedge bus_clk_w) begin
        if (!bus_rst_n_w) begin
            state_q    <= StIdle;
            half_q     <= 1'b0;
            low_q      <= '0;
            word_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            low_q      <= low_d;
            word_cnt_q <= word_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state, sample packing and push generation.
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        low_d      = low_q;
        word_cnt_d = word_cnt_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (!pipe.user_r_read_32_open) begin
            // Close aborts everything; overflow survives for the host to see.
            state_d = StIdle;
            flush   = 1'b1;
            half_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StWaitTrig;
                StWaitTrig: begin
                    if (trigger) begin
                        state_d    = StCapture;
                        overflow_d = 1'b0;
                        word_cnt_d = '0;
                        half_d     = 1'b0;
                    end
                end
                StCapture: begin
                    if (sample_valid) begin
                        if (!half_q) begin
                            low_d  = sample_in;
                            half_d = 1'b1;
                        end else begin
                            half_d     = 1'b0;
                            push       = 1'b1;
                            word_cnt_d = word_cnt_q + 1'b1;
                            if (blocked) overflow_d = 1'b1;
                            if (word_cnt_q == LastWord) state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (fifo_count == '0) state_d = StEof;
                end
                StEof:   state_d = StEof;
                default: state_d = StIdle;
            endcase
        end
    end

    us_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WORD_W     (WORD_W)
    ) u_fifo (
        .clk       (bus_clk_w),
        .rst_n     (bus_rst_n_w),
        .flush     (flush),
        .push      (push),
        .push_data ({sample_in, low_q}),
        .pop       (pipe.user_r_read_32_rden),
        .rd_data   (pipe.user_r_read_32_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pipe.user_r_read_32_empty = fifo_empty;
    assign pipe.user_r_read_32_eof   = (state_q == StEof);
    assign overflow                  = overflow_q;
    assign frame_active              = (state_q == StCapture);

endmodule

// File: tb/tb_us_frame_source.sv
// Bench for us_frame_source: dut0 (depth 512, 4-word frames) and dut1
// (depth 4, 8-word frames), checked against a word scoreboard.
module tb_us_frame_source;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] smp [2];
    logic [1:0]  sv, trg, opn, rdn;
    wire  [1:0]  ovf, fact, emp, eofs;
    wire  [31:0] dat0, dat1;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] sb0 [$];
    logic [31:0] sb1 [$];
    int mcnt [2];
    bit movf [2];

    always #5 clk = ~clk;

    us_frame_source_if ifc0 ();
    us_frame_source_if ifc1 ();

    assign ifc0.user_r_read_32_open = opn[0];
    assign ifc0.user_r_read_32_rden = rdn[0];
    assign ifc1.user_r_read_32_open = opn[1];
    assign ifc1.user_r_read_32_rden = rdn[1];
    assign emp[0]  = ifc0.user_r_read_32_empty;
    assign emp[1]  = ifc1.user_r_read_32_empty;
    assign eofs[0] = ifc0.user_r_read_32_eof;
    assign eofs[1] = ifc1.user_r_read_32_eof;
    assign dat0    = ifc0.user_r_read_32_data;
    assign dat1    = ifc1.user_r_read_32_data;

    us_frame_source #(.DEPTH_LOG2(9), .FRAME_WORDS(4)) dut0 (
        .bus_clk_w    (clk),
        .bus_rst_n_w  (rst_n),
        .sample_in    (smp[0]),
        .sample_valid (sv[0]),
        .trigger      (trg[0]),
        .pipe         (ifc0),
        .overflow     (ovf[0]),
        .frame_active (fact[0])
    );

    us_frame_source #(.DEPTH_LOG2(2), .FRAME_WORDS(8)) dut1 (
        .bus_clk_w    (clk),
        .bus_rst_n_w  (rst_n),
        .sample_in    (smp[1]),
        .sample_valid (sv[1]),
        .trigger      (trg[1]),
        .pipe         (ifc1),
        .overflow     (ovf[1]),
        .frame_active (fact[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int depth(input int d);
        return (d == 0) ? 512 : 4;
    endfunction

    task automatic sb_push(input int d, input logic [31:0] w);
        if (d == 0) sb0.push_back(w);
        else        sb1.push_back(w);
    endtask

    task automatic sb_pop_chk(input int d, input string tag);
        int          sz;
        logic [31:0] exp;
        logic [31:0] obs;
        sz  = (d == 0) ? sb0.size() : sb1.size();
        obs = (d == 0) ? dat0 : dat1;
        if (sz == 0) begin
            n_total++;
            $error("FAIL %s: observed %h expected none (scoreboard empty)", tag, obs);
        end else begin
            exp = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            chk(tag, obs, exp);
        end
    endtask

    task automatic sb_clear(input int d);
        if (d == 0) sb0.delete();
        else        sb1.delete();
        mcnt[d] = 0;
    endtask

    // Two back-to-back valid samples; rd raises rden on the second one.
    task automatic send_pair(input int d, input logic [15:0] lo, input logic [15:0] hi,
                             input bit rd, input bit tg);
        bit accept;
        smp[d] = lo; sv[d] = 1'b1; rdn[d] = 1'b0; trg[d] = tg;
        step();
        smp[d] = hi; rdn[d] = rd; trg[d] = 1'b0;
        step();
        rdn[d] = 1'b0;
        accept = (mcnt[d] < depth(d)) || rd;
        if (rd) begin
            sb_pop_chk(d, "rd_with_push");
            mcnt[d]--;
        end
        if (accept) begin
            sb_push(d, {hi, lo});
            mcnt[d]++;
        end else begin
            movf[d] = 1'b1;
        end
        chk("overflow", ovf[d], movf[d]);
    endtask

    task automatic read_one(input int d, input string tag);
        rdn[d] = 1'b1;
        step();
        rdn[d] = 1'b0;
        sb_pop_chk(d, tag);
        mcnt[d]--;
    endtask

    task automatic start_frame(input int d);
        trg[d] = 1'b1;
        step();
        trg[d] = 1'b0;
        movf[d] = 1'b0;
        chk("capture_entry", fact[d], 1);
        chk("ovf_cleared", ovf[d], 0);
    endtask

    task automatic close_pipe(input int d);
        opn[d] = 1'b0;
        sv[d]  = 1'b0;
        step();
        sb_clear(d);
        chk("close_empty", emp[d], 1);
        chk("close_eof", eofs[d], 0);
        chk("close_active", fact[d], 0);
    endtask

    // Last read just completed: eof must rise exactly one cycle later.
    task automatic eof_seq(input int d);
        chk("pre_eof", eofs[d], 0);
        chk("pre_eof_empty", emp[d], 1);
        step();
        chk("eof", eofs[d], 1);
        chk("eof_empty", emp[d], 1);
    endtask

    task automatic chk_reset_out(input int d);
        chk("rst_empty", emp[d], 1);
        chk("rst_eof", eofs[d], 0);
        chk("rst_data", (d == 0) ? dat0 : dat1, 0);
        chk("rst_ovf", ovf[d], 0);
        chk("rst_active", fact[d], 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        opn = 2'b11; sv = 2'b11; trg = 2'b00; rdn = 2'b00;
        smp[0] = 16'h0; smp[1] = 16'h0;
        mcnt[0] = 0; mcnt[1] = 0; movf[0] = 1'b0; movf[1] = 1'b0;

        // Reset with open high and samples toggling.
        for (int i = 0; i < 2; i++) begin
            smp[0] = (i == 0) ? 16'hA5A5 : 16'h5A5A;
            smp[1] = (i == 0) ? 16'h1234 : 16'hFEDC;
            step();
            chk_reset_out(0);
            chk_reset_out(1);
        end
        rst_n = 1'b1;
        sv    = 2'b00;
        step();
        chk_reset_out(0);
        chk_reset_out(1);

        // Basic frame on dut0.
        start_frame(0);
        for (int k = 0; k < 4; k++) send_pair(0, 16'(2 * k + 1), 16'(2 * k + 2), 1'b0, 1'b0);
        sv[0] = 1'b0;
        chk("basic_done", fact[0], 0);
        chk("basic_nonempty", emp[0], 0);
        for (int k = 9; k < 13; k++) begin
            smp[0] = 16'(k); sv[0] = 1'b1;
            step();
        end
        sv[0] = 1'b0;
        for (int k = 0; k < 4; k++) read_one(0, "basic_rd");
        eof_seq(0);
        smp[0] = 16'h00AA; sv[0] = 1'b1;
        step();
        step();
        sv[0] = 1'b0;
        chk("eof_hold", eofs[0], 1);
        chk("eof_no_capture", emp[0], 1);
        close_pipe(0);

        // Close mid-capture after three words.
        opn[0] = 1'b1;
        step();
        start_frame(0);
        for (int k = 0; k < 3; k++) send_pair(0, 16'h0100 + 16'(k), 16'h0200 + 16'(k), 1'b0, 1'b0);
        close_pipe(0);

        // Trigger while closed, then samples while waiting for trigger.
        trg[0] = 1'b1;
        step();
        trg[0] = 1'b0;
        smp[0] = 16'h0077; sv[0] = 1'b1;
        step();
        step();
        chk("idle_no_capture", fact[0], 0);
        opn[0] = 1'b1;
        step();
        step();
        step();
        sv[0] = 1'b0;
        chk("wait_no_capture", fact[0], 0);
        chk("wait_empty", emp[0], 1);

        // Clean frame after reopen; a second trigger mid-capture is ignored.
        start_frame(0);
        send_pair(0, 16'h0011, 16'h0012, 1'b0, 1'b0);
        send_pair(0, 16'h0013, 16'h0014, 1'b0, 1'b1);
        send_pair(0, 16'h0015, 16'h0016, 1'b0, 1'b0);
        send_pair(0, 16'h0017, 16'h0018, 1'b0, 1'b0);
        sv[0] = 1'b0;
        chk("retrig_done", fact[0], 0);
        for (int k = 0; k < 4; k++) read_one(0, "clean_rd");
        eof_seq(0);
        close_pipe(0);

        // Overflow on dut1: 8 words into a 4-deep FIFO with no reads.
        start_frame(1);
        for (int k = 0; k < 8; k++) send_pair(1, 16'h1000 + 16'(2 * k), 16'h1001 + 16'(2 * k),
                                              1'b0, 1'b0);
        sv[1] = 1'b0;
        chk("ovf_done", fact[1], 0);
        for (int k = 0; k < 4; k++) read_one(1, "ovf_rd");
        eof_seq(1);
        chk("ovf_sticky_eof", ovf[1], 1);
        close_pipe(1);
        chk("ovf_hold_close", ovf[1], 1);

        // Push into a full FIFO with a same-cycle read is not a drop.
        opn[1] = 1'b1;
        step();
        start_frame(1);
        for (int k = 0; k < 8; k++) send_pair(1, 16'h2000 + 16'(2 * k), 16'h2001 + 16'(2 * k),
                                              (k >= 4), 1'b0);
        sv[1] = 1'b0;
        chk("pp_done", fact[1], 0);
        chk("pp_no_ovf", ovf[1], 0);
        for (int k = 0; k < 4; k++) read_one(1, "pp_rd");
        eof_seq(1);
        close_pipe(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
